// File: rtl/ant_pkg.sv
// Shared definitions for the wall-following ant controller: move codes,
// the navigation state set and the pheromone code helpers.
package ant_pkg;

    // Move codes driven into the maze model
    typedef enum logic [1:0] {
        HALT    = 2'b00,
        RIGHT   = 2'b01,
        LEFT    = 2'b10,
        FORWARD = 2'b11
    } move_t;

    // Navigation states
    typedef enum logic [2:0] {
        IDLE,
        FOLLOW,
        TURN_IN,
        TURN_OUT,
        BACKOFF,
        DONE
    } state_t;

    // Corner marker left when the wall falls away while following it
    localparam int PH_CORNER = 1;

    // All-ones pheromone code of the given width (dead-end marker)
    function automatic logic [31:0] ph_dead(input int width);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Move code associated with the state being entered; the turn
    // direction depends on which hand is on the wall
    function automatic logic [1:0] move_for(input state_t s, input logic right_hand);
        logic [1:0] m;
        case (s)
            IDLE, FOLLOW: m = FORWARD;
            TURN_IN:      m = right_hand ? RIGHT : LEFT;
            TURN_OUT:     m = right_hand ? LEFT : RIGHT;
            default:      m = HALT;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ant_nav.sv
// Wall-following navigation FSM with selectable hand, hit back-off,
// stuck detection and pheromone marking. One registered move per clock.
module ant_nav #(
    parameter int PH_WIDTH    = 2,
    parameter int STUCK_LIMIT = 8,
    parameter int BACKOFF_CYC = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ant_l,
    input  logic                ant_r,
    input  logic                hit,
    input  logic                escape,
    input  logic                hand,
    input  logic [PH_WIDTH-1:0] ph_detected,
    output logic [1:0]          move,
    output logic [PH_WIDTH-1:0] ph_drop,
    output logic                done
);
    import ant_pkg::*;

    // The counter is shared by TURN_IN and BACKOFF, so it is sized for the
    // longer of the two dwells; both states leave before it could wrap.
    localparam int CNT_MAX = (STUCK_LIMIT > BACKOFF_CYC) ? STUCK_LIMIT : BACKOFF_CYC;
    localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0]    STUCK_LAST  = CNT_W'(STUCK_LIMIT - 1);
    localparam logic [CNT_W-1:0]    BACKOFF_LAST = CNT_W'(BACKOFF_CYC - 1);
    localparam logic [PH_WIDTH-1:0] PH_DEAD_CODE   = PH_WIDTH'(ph_dead(PH_WIDTH));
    localparam logic [PH_WIDTH-1:0] PH_CORNER_CODE = PH_WIDTH'(PH_CORNER);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             wall_c;
    logic             open_c;

    // Next-state decision: escape beats hit, hit beats the antenna rules
    always_comb begin
        wall_c     = hand ? ant_r : ant_l;
        open_c     = hand ? ant_l : ant_r;
        next_state = state;
        next_cnt   = '0;
        if (escape) begin
            next_state = DONE;
        end else if (hit && state != DONE) begin
            next_state = BACKOFF;
        end else begin
            case (state)
                IDLE: begin
                    if (open_c) begin
                        next_state = TURN_OUT;
                    end else if (wall_c) begin
                        next_state = FOLLOW;
                    end else if (ph_detected == PH_DEAD_CODE) begin
                        next_state = TURN_OUT;
                    end
                end
                FOLLOW: begin
                    if (open_c) begin
                        next_state = TURN_OUT;
                    end else if (!wall_c) begin
                        next_state = TURN_IN;
                    end
                end
                TURN_IN: begin
                    if (open_c) begin
                        next_state = TURN_OUT;
                    end else if (wall_c) begin
                        next_state = FOLLOW;
                    end else if (cnt == STUCK_LAST) begin
                        next_state = IDLE;
                    end else begin
                        next_cnt = cnt + CNT_W'(1);
                    end
                end
                TURN_OUT: begin
                    if (!open_c) begin
                        next_state = wall_c ? FOLLOW : TURN_IN;
                    end
                end
                BACKOFF: begin
                    if (cnt == BACKOFF_LAST) begin
                        next_state = TURN_OUT;
                    end else begin
                        next_cnt = cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    next_state = DONE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    // State and dwell counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Registered outputs decoded from the transition being taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            move    <= HALT;
            ph_drop <= '0;
            done    <= 1'b0;
        end else begin
            move <= move_for(next_state, hand);
            done <= (next_state == DONE);
            if (next_state == BACKOFF && state != BACKOFF) begin
                ph_drop <= PH_DEAD_CODE;
            end else if (state == FOLLOW && next_state == TURN_IN) begin
                ph_drop <= PH_CORNER_CODE;
            end else begin
                ph_drop <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ant_nav.sv
// Self-checking bench for ant_nav: directed scenarios with literal
// expectations, then randomized stimulus against a behavioural model.
module tb_ant_nav;

    localparam int PH_WIDTH    = 2;
    localparam int STUCK_LIMIT = 8;
    localparam int BACKOFF_CYC = 3;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ant_l = 1'b0;
    logic                ant_r = 1'b0;
    logic                hit = 1'b0;
    logic                escape = 1'b0;
    logic                hand = 1'b0;
    logic [PH_WIDTH-1:0] ph_detected = '0;
    logic [1:0]          move;
    logic [PH_WIDTH-1:0] ph_drop;
    logic                done;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    ant_nav #(
        .PH_WIDTH(PH_WIDTH),
        .STUCK_LIMIT(STUCK_LIMIT),
        .BACKOFF_CYC(BACKOFF_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ant_l(ant_l),
        .ant_r(ant_r),
        .hit(hit),
        .escape(escape),
        .hand(hand),
        .ph_detected(ph_detected),
        .move(move),
        .ph_drop(ph_drop),
        .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural model: modes named by what the ant is doing, with
    // "cycles left" budgets for the timed behaviours.
    localparam int M_WANDER = 0;
    localparam int M_HUG    = 1;
    localparam int M_SEEK   = 2;
    localparam int M_AVOID  = 3;
    localparam int M_STUN   = 4;
    localparam int M_EXIT   = 5;

    int         mode = M_WANDER;
    int         left_cycles = 0;
    int         nmode = M_WANDER;
    bit         w_side;
    bit         o_side;
    logic [1:0] exp_move = 2'b00;
    logic [1:0] exp_ph = 2'b00;
    logic       exp_done = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mode        = M_WANDER;
            left_cycles = 0;
            exp_move    = 2'b00;
            exp_ph      = 2'b00;
            exp_done    = 1'b0;
        end else begin
            w_side = hand ? ant_r : ant_l;
            o_side = hand ? ant_l : ant_r;
            exp_ph = 2'b00;
            nmode  = mode;
            if (mode == M_EXIT || escape) begin
                nmode = M_EXIT;
            end else if (hit) begin
                if (mode != M_STUN) exp_ph = 2'b11;
                nmode       = M_STUN;
                left_cycles = BACKOFF_CYC;
            end else if (mode == M_STUN) begin
                if (left_cycles > 1) left_cycles = left_cycles - 1;
                else nmode = M_AVOID;
            end else if (o_side) begin
                nmode = M_AVOID;
            end else if (w_side) begin
                nmode = M_HUG;
            end else begin
                case (mode)
                    M_WANDER: if (ph_detected == 2'b11) nmode = M_AVOID;
                    M_HUG: begin
                        nmode = M_SEEK;
                        left_cycles = STUCK_LIMIT;
                        exp_ph = 2'b01;
                    end
                    M_AVOID: begin
                        nmode = M_SEEK;
                        left_cycles = STUCK_LIMIT;
                    end
                    M_SEEK: begin
                        if (left_cycles > 1) left_cycles = left_cycles - 1;
                        else nmode = M_WANDER;
                    end
                    default: nmode = mode;
                endcase
            end
            mode = nmode;
            case (mode)
                M_WANDER, M_HUG: exp_move = 2'b11;
                M_SEEK:          exp_move = hand ? 2'b01 : 2'b10;
                M_AVOID:         exp_move = hand ? 2'b10 : 2'b01;
                default:         exp_move = 2'b00;
            endcase
            exp_done = (mode == M_EXIT);
        end
    end

    task automatic checkOutput(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic r, input logic h,
                                 input logic e, input logic hd,
                                 input logic [PH_WIDTH-1:0] ph);
        ant_l       = l;
        ant_r       = r;
        hit         = h;
        escape      = e;
        hand        = hd;
        ph_detected = ph;
        @(posedge clk);
        #1;
    endtask

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (checking) begin
            checkOutput("move", int'(move), int'(exp_move));
            checkOutput("ph_drop", int'(ph_drop), int'(exp_ph));
            checkOutput("done", int'(done), int'(exp_done));
        end
    end

    initial begin
        int regime;
        int contact_pct;

        // Reset and idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;
        checkOutput("rst_move", int'(move), 0);
        checkOutput("rst_ph", int'(ph_drop), 0);
        checkOutput("rst_done", int'(done), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 2'b00);
            checkOutput("idle_move", int'(move), 3);
        end
        checkOutput("idle_done", int'(done), 0);

        // Left-hand follow, then corner into TURN_IN
        applyStimulus(1, 0, 0, 0, 0, 2'b00);
        checkOutput("lfollow_move1", int'(move), 3);
        applyStimulus(1, 0, 0, 0, 0, 2'b00);
        checkOutput("lfollow_move2", int'(move), 3);
        applyStimulus(0, 0, 0, 0, 0, 2'b00);
        checkOutput("corner_move", int'(move), 2);
        checkOutput("corner_ph", int'(ph_drop), 1);

        // Stuck: TURN_IN lasts exactly STUCK_LIMIT cycles
        for (int i = 1; i < STUCK_LIMIT; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 2'b00);
            checkOutput("stuck_move", int'(move), 2);
            checkOutput("stuck_ph", int'(ph_drop), 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 2'b00);
        checkOutput("stuck_exit_move", int'(move), 3);

        // Right-hand mirror
        applyStimulus(1, 1, 0, 0, 1, 2'b00);
        checkOutput("rmirror_away", int'(move), 2);
        applyStimulus(0, 1, 0, 0, 1, 2'b00);
        checkOutput("rmirror_follow", int'(move), 3);

        // Hit back-off with a re-hit at back-off cycle 2
        applyStimulus(0, 1, 1, 0, 1, 2'b00);
        checkOutput("hit_move", int'(move), 0);
        checkOutput("hit_ph", int'(ph_drop), 3);
        applyStimulus(0, 1, 0, 0, 1, 2'b00);
        checkOutput("bo2_move", int'(move), 0);
        checkOutput("bo2_ph", int'(ph_drop), 0);
        applyStimulus(0, 1, 1, 0, 1, 2'b00);
        checkOutput("rehit_move", int'(move), 0);
        checkOutput("rehit_ph", int'(ph_drop), 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 0, 0, 1, 2'b00);
            checkOutput("rehit_hold", int'(move), 0);
        end
        applyStimulus(1, 1, 0, 0, 1, 2'b00);
        checkOutput("bo_exit_away", int'(move), 2);

        // Escape together with hit
        applyStimulus(0, 1, 1, 1, 1, 2'b00);
        checkOutput("esc_move", int'(move), 0);
        checkOutput("esc_done", int'(done), 1);
        checkOutput("esc_ph", int'(ph_drop), 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i[0], ~i[0], i[1], 0, i[0], 2'b11);
            checkOutput("done_hold_move", int'(move), 0);
            checkOutput("done_hold_done", int'(done), 1);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized run against the model
        regime = 0;
        contact_pct = 50;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 24 == 0) begin
                regime = int'($urandom_range(0, 2));
                contact_pct = (regime == 0) ? 5 : (regime == 1) ? 40 : 75;
            end
            if (exp_done || $urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
            end else begin
                applyStimulus($urandom_range(0, 99) < contact_pct,
                              $urandom_range(0, 99) < contact_pct,
                              $urandom_range(0, 19) == 0,
                              $urandom_range(0, 249) == 0,
                              ($urandom_range(0, 49) == 0) ? ~hand : hand,
                              PH_WIDTH'($urandom_range(0, 3)));
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ant_nav.md
# ant_nav

Parametrised successor to the team's single-hand ant controller: a wall-following navigation FSM with a selectable hand, hit back-off, stuck detection and pheromone marking. It sits between the maze model's antenna/hit/escape outputs and its move input. It issues one registered move code per clock until escape.

## Interface
Parameters:
- PH_WIDTH, 2: pheromone code width; must be at least 2.
- STUCK_LIMIT, 8: maximum consecutive TURN_IN cycles with no contact before the FSM gives up and wanders.
- BACKOFF_CYC, 3: number of HALT cycles after a hit; must be at least 1.

Ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst, in, 1: asynchronous, active-high reset.
- ant_l, in, 1: left antenna contact.
- ant_r, in, 1: right antenna contact.
- hit, in, 1: collision flag.
- escape, in, 1: maze exit reached.
- hand, in, 1: 0 = left-hand rule, 1 = right-hand rule.
- ph_detected, in, PH_WIDTH: pheromone code under the ant.
- move, out, 2: registered move code.
- ph_drop, out, PH_WIDTH: registered pheromone deposit; 0 means none.
- done, out, 1: sticky escape flag.

## Operation
Side mapping:
- w = hand ? ant_r : ant_l (wall side).
- o = hand ? ant_l : ant_r (open side).
- TOWARD = hand ? RIGHT : LEFT.
- AWAY = hand ? LEFT : RIGHT.
- hand is sampled every cycle; changing it mid-run simply swaps w/o from the next edge.

Priority of the next-state decision, highest first:
1. escape from any state goes to DONE.
2. hit from any state except DONE goes to BACKOFF with cnt = 0. A hit while already in BACKOFF restarts cnt at 0.
3. Antenna rules for the current state.

States and move decode (move is a function of the state being entered):
- IDLE, FORWARD.
  - w & !o goes to FOLLOW.
  - o goes to TURN_OUT.
  - No contact with ph_detected == PH_DEAD goes to TURN_OUT.
  - Otherwise stay in IDLE.
- FOLLOW, FORWARD.
  - w & !o stays.
  - o goes to TURN_OUT.
  - No contact goes to TURN_IN.
- TURN_IN, TOWARD.
  - w & !o goes to FOLLOW.
  - o goes to TURN_OUT.
  - No contact: cnt increments. When cnt == STUCK_LIMIT-1, go to IDLE instead.
- TURN_OUT, AWAY.
  - o stays.
  - w & !o goes to FOLLOW.
  - No contact goes to TURN_IN.
- BACKOFF, HALT.
  - cnt increments each cycle.
  - When cnt == BACKOFF_CYC-1, go to TURN_OUT.
  - Antenna inputs are ignored in this state.
- DONE, HALT. Terminal until rst.

Shared counter:
- cnt is cleared on every state change.
- Width is $clog2(max(STUCK_LIMIT, BACKOFF_CYC)).
- cnt never wraps, because every state that counts leaves before overflow.

Pheromone marks:
- PH_CORNER = 1; PH_DEAD = all ones.
- ph_drop = PH_CORNER for the one cycle in which the FSM enters TURN_IN from FOLLOW.
- ph_drop = PH_DEAD for the cycle in which BACKOFF is entered from a non-BACKOFF state.
- ph_drop = 0 otherwise.
- If both conditions apply on the same edge, PH_DEAD wins (hit has priority).

## Timing
- Reset values: state IDLE, move HALT, ph_drop 0, done 0, cnt 0.
- Latency: inputs are sampled at edge N; move, ph_drop and done reflect them after edge N. This is one cycle of latency with no combinational input-to-output path.
- First edge after rst deasserts with no contact: move = FORWARD.
- done rises on the same edge that enters DONE.
- Simultaneous escape and hit: DONE wins, and no PH_DEAD is dropped.
- Reset asserted mid-BACKOFF or mid-TURN_IN: immediate return to the reset values, with the counter cleared.
- TURN_IN dwell with no contact is exactly STUCK_LIMIT cycles.
- BACKOFF dwell is exactly BACKOFF_CYC cycles after the last hit.

## Structure
- Package ant_pkg holds:
  - Move codes: HALT = 2'b00, RIGHT = 2'b01, LEFT = 2'b10, FORWARD = 2'b11.
  - The state enum (IDLE, FOLLOW, TURN_IN, TURN_OUT, BACKOFF, DONE).
  - Function ph_dead(width) that returns the all-ones code.
- Single module. No sub-module is warranted: the counter and hand mux are trivial. Split into three parts:
  - the state/cnt register,
  - the next-state logic,
  - the output decode register.

## Test plan
All scenarios use the default parameters.
- Reset and idle: rst pulse, then no contact for 3 cycles -> move HALT during reset, then 11, 11, 11; done 0.
- Left-hand follow: hand = 0, ant_l = 1 for 2 cycles, then contact removed -> move 11, 11, then 10. ph_drop = 1 on that edge and 0 on the next.
- Right-hand mirror: hand = 1, both antennae = 1 -> move 10 (AWAY). Then ant_r = 1 only -> move 11.
- Stuck: enter TURN_IN, keep no contact -> move 10 for exactly 8 cycles, then 11 (IDLE).
- Hit back-off: hit pulse in FOLLOW -> ph_drop = 2'b11 for one cycle and move 00 for 3 cycles, then AWAY. A second hit at back-off cycle 2 extends the HALT to 3 cycles from the second hit, with no second PH_DEAD.
- Escape priority: escape and hit asserted together -> move 00, done 1, ph_drop 0. done and move stay fixed under further antenna toggling until rst.
